operand_sender: RTL and testbench

OPERAND_SENDER -- requirements
Module: operand_sender

---
 rtl/operand_sender_if.sv | 23 ++
 rtl/operand_sender.sv | 129 ++++++++++++
 tb/tb_operand_sender.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_sender_if.sv
// Operand bus between the sender, its requester and the downstream 4-bit comparator.
interface operand_sender_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       eq;
    logic [3:0] data_out;
    logic       push1;
    logic       push2;
    logic       busy;
    logic       done;
    logic       result;

    modport master (
        input  start, a, b, eq,
        output data_out, push1, push2, busy, done, result
    );

    modport slave (
        output start, a, b, eq,
        input  data_out, push1, push2, busy, done, result
    );
endinterface

// File: rtl/operand_sender.sv
// Serialises an operand pair onto a shared 4-bit bus with timed push strobes, then samples
// the comparator's eq after a settle window. Every output comes straight from a flop.
module operand_sender #(
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    operand_sender_if.master bus
);

    localparam logic [7:0] HoldLoad   = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup1,
        StP1,
        StSetup2,
        StP2,
        StSettle,
        StDone
    } state_e;

    state_e     r_state, w_state_d;
    logic [7:0] r_cnt, w_cnt_d;
    logic [3:0] r_a, w_a_d;
    logic [3:0] r_b, w_b_d;
    logic [3:0] r_data, w_data_d;
    logic       r_push1, w_push1_d;
    logic       r_push2, w_push2_d;
    logic       r_busy, w_busy_d;
    logic       r_done, w_done_d;
    logic       r_result, w_result_d;

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_a_d      = r_a;
        w_b_d      = r_b;
        w_result_d = r_result;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_d = StSetup1;
                    w_a_d     = bus.a;
                    w_b_d     = bus.b;
                end
            end
            StSetup1: begin
                w_state_d = StP1;
                w_cnt_d   = HoldLoad;
            end
            StP1: begin
                if (r_cnt == 8'd0) w_state_d = StSetup2;
                else               w_cnt_d   = r_cnt - 8'd1;
            end
            StSetup2: begin
                w_state_d = StP2;
                w_cnt_d   = HoldLoad;
            end
            StP2: begin
                if (r_cnt == 8'd0) begin
                    w_state_d = StSettle;
                    w_cnt_d   = SettleLoad;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StSettle: begin
                if (r_cnt == 8'd0) begin
                    w_state_d  = StDone;
                    w_result_d = bus.eq;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        w_push1_d = (w_state_d == StP1);
        w_push2_d = (w_state_d == StP2);
        w_busy_d  = (w_state_d != StIdle);
        w_done_d  = (w_state_d == StDone);

        unique case (w_state_d)
            StSetup1, StP1:                    w_data_d = w_a_d;
            StSetup2, StP2, StSettle, StDone:  w_data_d = w_b_d;
            default:                           w_data_d = r_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= 8'd0;
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_data   <= 4'd0;
            r_push1  <= 1'b0;
            r_push2  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_a      <= w_a_d;
            r_b      <= w_b_d;
            r_data   <= w_data_d;
            r_push1  <= w_push1_d;
            r_push2  <= w_push2_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_result <= w_result_d;
        end
    end

    assign bus.data_out = r_data;
    assign bus.push1    = r_push1;
    assign bus.push2    = r_push2;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;

endmodule

// File: tb/tb_operand_sender.sv
// Bench for operand_sender: a transaction-timeline model plus a behavioural comparator on eq.
module tb_operand_sender;

    localparam int HOLD   = 8;
    localparam int SETTLE = 4;
    localparam int LAT    = 3 + 2 * HOLD + SETTLE;
    localparam int P2_J   = 3 + HOLD + 2;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic exp_result;
    logic mon_en;
    logic [3:0] mon_prev;

    logic [3:0] cmp_op1 = 4'd0;
    logic [3:0] cmp_op2 = 4'd0;

    operand_sender_if bus ();

    operand_sender #(
        .HOLD_CYCLES  (HOLD),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream comparator: captures the bus on each strobe, eq is a plain equality.
    always @(posedge clk) begin
        if (bus.push1) cmp_op1 <= bus.data_out;
        if (bus.push2) cmp_op2 <= bus.data_out;
    end
    assign bus.eq = (cmp_op1 == cmp_op2);

    // Strobe exclusivity and bus stability, checked every cycle once out of reset.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.push1 && bus.push2) begin
                errors++;
                $display("FAIL push_overlap push1=%b push2=%b required not both 1",
                         bus.push1, bus.push2);
            end
            checks++;
            if (bus.data_out !== mon_prev && (bus.push1 || bus.push2)) begin
                errors++;
                $display("FAIL bus_stable data_out %h->%h with push1=%b push2=%b",
                         mon_prev, bus.data_out, bus.push1, bus.push2);
            end
        end
        mon_prev = bus.data_out;
    end

    function automatic logic [8:0] observed();
        return {bus.busy, bus.push1, bus.push2, bus.done, bus.result, bus.data_out};
    endfunction

    // Expected outputs at cycle offset j after the accepting edge.
    function automatic logic [8:0] expect_at(input int j, input logic [3:0] ta,
                                             input logic [3:0] tb_, input logic res);
        logic [3:0] d;
        d = (j <= 1 + HOLD) ? ta : tb_;
        return {j <= LAT, (j >= 2) && (j <= 1 + HOLD), (j >= 3 + HOLD) && (j <= 2 + 2 * HOLD),
                j == LAT, res, d};
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 4'hf;
        bus.b     = 4'hf;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (observed() !== 9'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%b required=%b", i, observed(), 9'd0);
            end
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (observed() !== 9'd0) begin
            errors++;
            $display("FAIL reset_release got=%b required=%b", observed(), 9'd0);
        end
        exp_result = 1'b0;
        mon_en     = 1'b1;
    endtask

    task automatic test_transaction(input logic [3:0] ta, input logic [3:0] tb_);
        logic [8:0] exp;
        bus.a     = ta;
        bus.b     = tb_;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int j = 1; j <= LAT + 1; j++) begin
            bus.a = 4'($urandom);
            bus.b = 4'($urandom);
            if (j == LAT) exp_result = (ta == tb_);
            exp = expect_at(j, ta, tb_, exp_result);
            checks++;
            if (observed() !== exp) begin
                errors++;
                $display("FAIL txn a=%h b=%h cyc=%0d got=%b required=%b",
                         ta, tb_, j, observed(), exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_result_hold();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.result !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL result_hold cyc=%0d result=%b busy=%b required result=1 busy=0",
                         i, bus.result, bus.busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.a     = 4'h3;
        bus.b     = 4'h3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int j = 1; j < P2_J; j++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.push2 !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_p2 push2=%b required=1", bus.push2);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (observed() !== 9'd0) begin
            errors++;
            $display("FAIL mid_reset got=%b required=%b", observed(), 9'd0);
        end
        rst_n      = 1'b1;
        exp_result = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 1'b0) begin
                errors++;
                $display("FAIL mid_after cyc=%0d busy=%b done=%b result=%b required all 0",
                         i, bus.busy, bus.done, bus.result);
            end
        end
        test_transaction(4'h3, 4'h3);
    endtask

    task automatic test_ignore_start();
        int done_cnt;
        done_cnt  = 0;
        bus.a     = 4'ha;
        bus.b     = 4'h5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int j = 1; j <= LAT + 4; j++) begin
            if (j == 4 || j == LAT) begin
                bus.start = 1'b1;
                bus.a     = 4'hf;
                bus.b     = 4'hf;
            end else if (j == 5 || j == LAT + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) done_cnt++;
            checks++;
            if (bus.data_out === 4'hf) begin
                errors++;
                $display("FAIL ignore_data cyc=%0d data_out=%h required not f", j, bus.data_out);
            end
            if (j >= LAT + 1) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_queued cyc=%0d busy=%b required=0", j, bus.busy);
                end
            end
            @(posedge clk); #1;
        end
        exp_result = 1'b0;
        checks++;
        if (done_cnt != 1 || bus.result !== exp_result) begin
            errors++;
            $display("FAIL ignore_done done_pulses=%0d result=%b required 1 pulse result=0",
                     done_cnt, bus.result);
        end
    endtask

    task automatic test_random();
        logic [3:0] ra, rb;
        for (int n = 0; n < 5; n++) begin
            ra = 4'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? ra : 4'($urandom);
            test_transaction(ra, rb);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] qa[3];
        logic [3:0] qb[3];
        logic [8:0] exp;
        for (int n = 0; n < 3; n++) begin
            qa[n] = 4'($urandom);
            qb[n] = 4'($urandom);
        end
        qb[1]     = qa[1];
        bus.a     = qa[0];
        bus.b     = qb[0];
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 3; n++) begin
            for (int j = 1; j <= LAT + 1; j++) begin
                if (j == LAT + 1 && n < 2) begin
                    bus.a = qa[n+1];
                    bus.b = qb[n+1];
                end else begin
                    bus.a = 4'($urandom);
                    bus.b = 4'($urandom);
                end
                if (j == LAT && n == 2) bus.start = 1'b0;
                if (j == LAT) exp_result = (qa[n] == qb[n]);
                exp = expect_at(j, qa[n], qb[n], exp_result);
                checks++;
                if (observed() !== exp) begin
                    errors++;
                    $display("FAIL b2b txn=%0d cyc=%0d got=%b required=%b",
                             n, j, observed(), exp);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        mon_en     = 1'b0;
        exp_result = 1'b0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.a      = 4'd0;
        bus.b      = 4'd0;
        test_reset();
        test_transaction(4'b0100, 4'b1000);
        test_transaction(4'b0110, 4'b0110);
        test_result_hold();
        test_reset_mid();
        test_ignore_start();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
